// File: rtl/audio_frame_packer.sv
// Pairs interleaved L/R AXI-Stream words into averaged mono samples, buffers them
// in a first-word-fall-through FIFO and emits FRAME_LEN-sample frames with TLAST.
module audio_frame_packer #(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24,
  parameter int FRAME_LEN    = 1024,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          AXIS_ACLK,
  input  logic                          AXIS_ARESETN,
  input  logic                          S_AXIS_TVALID,
  output logic                          S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0]         S_AXIS_TDATA,
  input  logic                          S_AXIS_TLAST,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic                          M_AXIS_TLAST,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   sync_errors,
  output logic [15:0]                   frame_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int EXT_W = DATA_WIDTH - SAMPLE_WIDTH;

  typedef enum logic {WAIT_L, WAIT_R} state_t;

  state_t                    state_q, state_d;
  logic [SAMPLE_WIDTH-1:0]   l_q;
  logic                      l_load, err_inc, wr_en, rd_en, s_hs;
  logic [SAMPLE_WIDTH-1:0]   in_sample, mono, head_d, tdata_q;
  logic [SAMPLE_WIDTH:0]     sum;
  logic [SAMPLE_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q, rd_ptr_nx;
  logic [LVL_W-1:0]          level_q, level_after_rd, level_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      tvalid_q, tlast_q;
  logic [15:0]               sync_errors_q, frame_count_q;
  logic                      unused_bits;

  assign in_sample = S_AXIS_TDATA[DATA_WIDTH-1 -: SAMPLE_WIDTH];
  assign unused_bits = ^{S_AXIS_TDATA[EXT_W-1:0], sum[0]};

  // Sign-extend both channels one bit so the sum cannot overflow; dropping
  // bit 0 is the arithmetic shift that rounds toward -inf.
  assign sum  = {l_q[SAMPLE_WIDTH-1], l_q} + {in_sample[SAMPLE_WIDTH-1], in_sample};
  assign mono = sum[SAMPLE_WIDTH:1];

  assign rd_en         = tvalid_q & M_AXIS_TREADY;
  assign S_AXIS_TREADY = (state_q == WAIT_L) || (level_q != LVL_W'(FIFO_DEPTH)) || rd_en;
  assign s_hs          = S_AXIS_TVALID & S_AXIS_TREADY;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    l_load  = 1'b0;
    err_inc = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      WAIT_L: if (s_hs) begin
        if (S_AXIS_TLAST) err_inc = 1'b1;
        else begin
          l_load  = 1'b1;
          state_d = WAIT_R;
        end
      end
      WAIT_R: if (s_hs) begin
        if (S_AXIS_TLAST) begin
          wr_en   = 1'b1;
          state_d = WAIT_L;
        end else begin
          l_load  = 1'b1;
          err_inc = 1'b1;
        end
      end
      default: state_d = WAIT_L;
    endcase
  end

  // Next head of the FIFO: a write into a FIFO that is empty after this
  // cycle's read bypasses straight to the output register.
  always_comb begin
    rd_ptr_nx      = rd_ptr_q + PTR_W'(rd_en);
    level_after_rd = level_q - LVL_W'(rd_en);
    level_d        = level_after_rd + LVL_W'(wr_en);
    idx_d          = idx_q + IDX_W'(rd_en);
    head_d         = (wr_en && level_after_rd == '0) ? mono : mem[rd_ptr_nx];
  end

  // NOTE: sample storage has no reset; valid data is tracked by the pointers and level.
  always_ff @(posedge AXIS_ACLK) begin
    if (wr_en) mem[wr_ptr_q] <= mono;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q       <= WAIT_L;
      l_q           <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      idx_q         <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
      sync_errors_q <= '0;
      frame_count_q <= '0;
    end else begin
      state_q  <= state_d;
      if (l_load) l_q <= in_sample;
      wr_ptr_q <= wr_ptr_q + PTR_W'(wr_en);
      rd_ptr_q <= rd_ptr_nx;
      level_q  <= level_d;
      idx_q    <= idx_d;
      tvalid_q <= (level_d != '0);
      tlast_q  <= (level_d != '0) && (idx_d == IDX_W'(FRAME_LEN - 1));
      if (level_d != '0) tdata_q <= head_d;
      if (err_inc && sync_errors_q != 16'hFFFF) sync_errors_q <= sync_errors_q + 16'd1;
      if (rd_en && tlast_q) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TDATA  = {{EXT_W{tdata_q[SAMPLE_WIDTH-1]}}, tdata_q};
  assign fifo_level    = level_q;
  assign sync_errors   = sync_errors_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_audio_frame_packer.sv
// Self-checking bench for audio_frame_packer: table-driven arithmetic vectors,
// a scoreboard of expected mono samples, and hand-written framing/backpressure sequences.
module tb_audio_frame_packer;

  localparam int FL = 8;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        m_tvalid, m_tready = 1'b1, m_tlast;
  logic [31:0] m_tdata;
  logic [4:0]  fifo_level;
  logic [15:0] sync_errors, frame_count;

  always #5 clk = ~clk;

  audio_frame_packer #(.DATA_WIDTH(32), .SAMPLE_WIDTH(24), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata), .S_AXIS_TLAST(s_tlast),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(m_tdata), .M_AXIS_TLAST(m_tlast),
    .fifo_level(fifo_level), .sync_errors(sync_errors), .frame_count(frame_count)
  );

  typedef struct { logic [31:0] data; logic last; } exp_t;
  typedef struct { logic [31:0] l; logic [31:0] r; logic [31:0] exp; } vec_t;

  exp_t        sb[$];
  int          n_checks = 0, n_pass = 0;
  logic        m_wait_r = 1'b0;
  logic [31:0] m_l = '0;
  int          m_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Floor-average of the two signed 24-bit samples held in [31:8].
  function automatic logic [31:0] avg(input logic [31:0] l, input logic [31:0] r);
    int ls, rs, s;
    ls = int'($signed(l[31:8]));
    rs = int'($signed(r[31:8]));
    s  = (ls + rs) >>> 1;
    return s;
  endfunction

  task automatic model_step(input logic [31:0] data, input logic last);
    if (!m_wait_r) begin
      if (!last) begin m_l = data; m_wait_r = 1'b1; end
    end else if (last) begin
      sb.push_back('{avg(m_l, data), (m_idx == FL - 1)});
      m_idx    = (m_idx + 1) % FL;
      m_wait_r = 1'b0;
    end else begin
      m_l = data;
    end
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    bit done = 0;
    s_tvalid = 1'b1; s_tdata = data; s_tlast = last;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (s_tready) done = 1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: s_tready stayed 0 for word 0x%08h", data);
      s_tvalid = 1'b0;
    end else begin
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      model_step(data, last);
    end
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
    send_word(l, 1'b0);
    send_word(r, 1'b1);
  endtask

  task automatic apply_reset(input logic ready);
    @(posedge clk); #1;
    rst_n = 1'b0; s_tvalid = 1'b0; m_tready = ready;
    sb.delete(); m_wait_r = 1'b0; m_idx = 0;
    #2;
    check("rst_valid_last_sready", {29'd0, m_tvalid, m_tlast, s_tready}, 32'd1);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_level", {27'd0, fifo_level}, 32'd0);
    check("rst_counters", {sync_errors, frame_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500; i++) begin
      if (sb.size() == 0 && !m_tvalid) break;
      @(negedge clk);
    end
    check("drain_queue", 32'(sb.size()), 32'd0);
    check("drain_level", {27'd0, fifo_level}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard: a handshake happens at the posedge following a negedge where both are high.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got 0x%08h with nothing expected", m_tdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", m_tdata, e.data);
        check("out_last", {31'd0, m_tlast}, {31'd0, e.last});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h80000000, 32'h7FFFFF00, 32'hFFFFFFFF};
    vecs[1] = '{32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFFFF};
    vecs[2] = '{32'h00000100, 32'h00000000, 32'h00000000};
    vecs[3] = '{32'hFFFFFF00, 32'h00000000, 32'hFFFFFFFF};
    vecs[4] = '{32'h7FFFFF00, 32'h7FFFFF00, 32'h007FFFFF};
    vecs[5] = '{32'h80000000, 32'h80000000, 32'hFF800000};
    vecs[6] = '{32'h000002FF, 32'h000004AB, 32'h00000003};

    apply_reset(1'b1);

    // Basic average and one-cycle output latency.
    send_word(32'h00100000, 1'b0);
    check("t1_no_early_valid", {31'd0, m_tvalid}, 32'd0);
    send_word(32'h00300000, 1'b1);
    check("t1_valid_latency", {31'd0, m_tvalid}, 32'd1);
    check("t1_data", m_tdata, 32'h00002000);
    check("t1_last", {31'd0, m_tlast}, 32'd0);

    foreach (vecs[i]) begin
      send_pair(vecs[i].l, vecs[i].r);
      check($sformatf("vec%0d_data", i), m_tdata, vecs[i].exp);
    end
    wait_drain();

    // 20 pairs streaming: TLAST on outputs 7 and 15.
    apply_reset(1'b1);
    for (int i = 0; i < 20; i++) send_pair($urandom, $urandom);
    wait_drain();
    check("t3_frame_count", {16'd0, frame_count}, 32'd2);

    // Backpressure: fill the FIFO, stall the 17th R, then release.
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) send_pair($urandom, $urandom);
    send_word(32'h12345600, 1'b0);
    s_tvalid = 1'b1; s_tdata = 32'h00ABCD00; s_tlast = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_level_full", {27'd0, fifo_level}, 32'd16);
    check("t4_s_tready_low", {31'd0, s_tready}, 32'd0);
    @(posedge clk); #1;
    m_tready = 1'b1;
    send_word(32'h00ABCD00, 1'b1);
    send_pair($urandom, $urandom);
    wait_drain();

    // Channel misalignment: orphan R, then L replaced before R.
    send_word(32'h00055500, 1'b1);
    send_word(32'h12345600, 1'b0);
    send_word(32'h00000400, 1'b0);
    send_word(32'h00000A00, 1'b1);
    check("t5_data", m_tdata, 32'h00000007);
    wait_drain();
    check("t5_sync_errors", {16'd0, sync_errors}, 32'd2);

    // Reset mid-frame with samples still queued.
    apply_reset(1'b0);
    for (int i = 0; i < 8; i++) send_pair($urandom, $urandom);
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_tready = 1'b0;
    check("t6_level_before_reset", {27'd0, fifo_level}, 32'd5);
    apply_reset(1'b1);
    for (int i = 0; i < 8; i++) send_pair($urandom, $urandom);
    wait_drain();
    check("t6_frame_count", {16'd0, frame_count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
